// File: rtl/program_loader_pkg.sv
// Shared state encoding and word-packing constants for the boot program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic is_hdr_or_data(input state_t s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/program_loader_packer.sv
// Big-endian byte-to-word packer: word/word_valid are presented combinationally with the 4th byte.
module program_loader_packer
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shreg_p0;
    logic [1:0]  cnt_p0;

    assign word       = {shreg_p0, in_byte};
    assign word_valid = en && (cnt_p0 == 2'(WORD_BYTES - 1));

    // Stage p0: earlier bytes of the current word; count wraps to 0 after the 4th byte
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shreg_p0 <= '0;
            cnt_p0   <= '0;
        end else if (en) begin
            shreg_p0 <= {shreg_p0[15:0], in_byte};
            cnt_p0   <= cnt_p0 + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed image into word memory and releases the CPU when complete.
// Build option LOADER_CHECKSUM_EN adds an XOR trailer byte checked before DONE.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_ST = ST_CHECK;
    logic [7:0] csum;
`else
    localparam state_t TAIL_ST = ST_DONE;
`endif

    state_t                state;
    logic [7:0]            n_hi;
    logic [ADDR_WIDTH-1:0] widx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [15:0]           hdr_n;
    logic                  accept;
    logic [31:0]           word;
    logic                  word_valid;

    assign accept = in_valid && in_ready;
    assign hdr_n  = {n_hi, in_byte};

    program_loader_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (state != ST_DATA),
        .en         (accept && (state == ST_DATA)),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // in_ready is registered from the next state, so in_valid never reaches it combinationally
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_HDR_HI;
            in_ready       <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            cpu_run        <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            n_hi           <= '0;
            widx           <= '0;
            last_idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            mem_write_en <= 1'b0;
            in_ready     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (accept && is_hdr_or_data(state))
                csum <= csum ^ in_byte;
`endif
            case (state)
                ST_HDR_HI: begin
                    if (accept) begin
                        n_hi  <= in_byte;
                        state <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        if (hdr_n > MAX_N) begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                            in_ready   <= 1'b0;
                        end else if (hdr_n == 16'd0) begin
                            state    <= TAIL_ST;
                            in_ready <= (TAIL_ST != ST_DONE);
                        end else begin
                            last_idx <= ADDR_WIDTH'(hdr_n - 16'd1);
                            widx     <= '0;
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        mem_write_en   <= 1'b1;
                        mem_addr       <= widx;
                        mem_write_data <= word;
                        if (widx == last_idx) begin
                            state    <= TAIL_ST;
                            in_ready <= (TAIL_ST != ST_DONE);
                        end else begin
                            widx <= widx + ADDR_WIDTH'(1);
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_byte == csum) begin
                            state <= ST_DONE;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                // Release lags DONE entry by one cycle so it follows the final write strobe
                ST_DONE: begin
                    in_ready  <= 1'b0;
                    load_done <= 1'b1;
                    cpu_run   <= 1'b1;
                end
                ST_ERROR: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state      <= ST_ERROR;
                    load_error <= 1'b1;
                    in_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
